// File: rtl/tx_pkg.sv
// Shared types and helpers for the transmit-side serializer blocks.
package tx_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/iq_hold_buf.sv
// One-entry valid/ready holding register; ready depends only on the full flag.
module iq_hold_buf #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          load,
    output logic [DW-1:0] data,
    output logic          full
);

    assign in_ready = !full;

    // load only happens while full, so it never collides with an accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            data <= in_data;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/iq_bit_serializer.sv
// I/Q pair to interleaved serial bit stream, one bit per CLK_1 edge.
module iq_bit_serializer
    import tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1,
    parameter bit IDLE_BIT  = 0
) (
    input  logic             CLK_1,
    input  logic             RST,
    input  logic [WIDTH-1:0] I_IN,
    input  logic [WIDTH-1:0] Q_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             DAC_OUT,
    output logic             PHASE_I,
    output logic             FRAME_START,
    output logic             UNDERRUN
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    logic [2*WIDTH-1:0] buf_data;
    logic               buf_full;
    logic               load;
    state_t             state;
    logic [WIDTH-1:0]   sh_i;
    logic [WIDTH-1:0]   sh_q;
    logic [CW-1:0]      bit_cnt;
    logic [CW-1:0]      nxt_cnt;
    logic [CW-2:0]      nxt_k;
    logic [WIDTH-1:0]   ord_i;
    logic [WIDTH-1:0]   ord_q;

    // shifters hold words in transmit order so bit k is always sent k-th
    function automatic logic [WIDTH-1:0] tx_order(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = MSB_FIRST ? w[WIDTH-1-b] : w[b];
        end
        return r;
    endfunction

    iq_hold_buf #(.DW(2 * WIDTH)) u_buf (
        .clk      (CLK_1),
        .rst      (RST),
        .in_data  ({I_IN, Q_IN}),
        .in_valid (IN_VALID),
        .in_ready (IN_READY),
        .load     (load),
        .data     (buf_data),
        .full     (buf_full)
    );

    assign ord_i   = tx_order(buf_data[2*WIDTH-1:WIDTH]);
    assign ord_q   = tx_order(buf_data[WIDTH-1:0]);
    assign load    = buf_full && (state == IDLE || bit_cnt == LAST);
    assign nxt_cnt = bit_cnt + 1'b1;
    assign nxt_k   = nxt_cnt[CW-1:1];

    always_ff @(posedge CLK_1 or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            sh_i        <= '0;
            sh_q        <= '0;
            bit_cnt     <= '0;
            DAC_OUT     <= IDLE_BIT;
            PHASE_I     <= 1'b0;
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;
        end else begin
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;
            if (load) begin
                state       <= SHIFT;
                sh_i        <= ord_i;
                sh_q        <= ord_q;
                bit_cnt     <= '0;
                DAC_OUT     <= ord_i[0];
                PHASE_I     <= 1'b1;
                FRAME_START <= 1'b1;
            end else if (state == SHIFT) begin
                if (bit_cnt == LAST) begin
                    state    <= IDLE;
                    DAC_OUT  <= IDLE_BIT;
                    PHASE_I  <= 1'b0;
                    UNDERRUN <= 1'b1;
                end else begin
                    bit_cnt <= nxt_cnt;
                    DAC_OUT <= nxt_cnt[0] ? sh_q[nxt_k] : sh_i[nxt_k];
                    PHASE_I <= !nxt_cnt[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_bit_serializer.sv
// Randomized self-checking bench for iq_bit_serializer (MSB- and LSB-first).
module tb_iq_bit_serializer;

    localparam int W = 8;
    localparam int FL = 2 * W;

    logic CLK_1 = 1'b0;
    logic RST = 1'b0;
    logic [W-1:0] i0 = '0, q0 = '0, i1 = '0, q1 = '0;
    logic v0 = 1'b0, v1 = 1'b0;
    logic r0, d0, p0, f0, u0;
    logic r1, d1, p1, f1, u1;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] pi[$];
    logic [W-1:0] pq[$];

    always #5 CLK_1 = ~CLK_1;

    iq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(0)) dut_msb (
        .CLK_1(CLK_1), .RST(RST), .I_IN(i0), .Q_IN(q0), .IN_VALID(v0),
        .IN_READY(r0), .DAC_OUT(d0), .PHASE_I(p0), .FRAME_START(f0),
        .UNDERRUN(u0)
    );

    iq_bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(0)) dut_lsb (
        .CLK_1(CLK_1), .RST(RST), .I_IN(i1), .Q_IN(q1), .IN_VALID(v1),
        .IN_READY(r1), .DAC_OUT(d1), .PHASE_I(p1), .FRAME_START(f1),
        .UNDERRUN(u1)
    );

    // frame bit j: even j from I, odd from Q; bit index from position k=j/2
    function automatic logic exp_bit(input logic [W-1:0] i, input logic [W-1:0] q,
                                     input int j, input bit msb);
        int k;
        int idx;
        logic [W-1:0] w;
        k = j / 2;
        idx = msb ? (W - 1 - k) : k;
        w = (j % 2 == 0) ? i : q;
        return w[idx];
    endfunction

    // {ready, dac, phase, frame_start, underrun}
    function automatic logic [4:0] obs(input bit lsb);
        return lsb ? {r1, d1, p1, f1, u1} : {r0, d0, p0, f0, u0};
    endfunction

    task automatic test_reset;
        logic [4:0] o;
        #17;
        for (int s = 0; s < 2; s++) begin
            o = obs(s[0]);
            nvec++;
            if (o !== 5'b10000) begin
                nerr++;
                $display("FAIL reset_hold dut%0d: rdy/dac/ph/fs/un=%b exp=10000", s, o);
            end
        end
        @(negedge CLK_1);
        RST = 1'b1;
        repeat (3) begin
            @(negedge CLK_1);
            o = obs(1'b0);
            nvec++;
            if (o !== 5'b10000) begin
                nerr++;
                $display("FAIL reset_release_idle: outputs=%b exp=10000", o);
            end
        end
    endtask

    task automatic test_single(input string nm, input bit lsb, input logic [W-1:0] i,
                               input logic [W-1:0] q, input logic [FL-1:0] gold);
        logic [4:0] o;
        logic [4:0] e;
        @(negedge CLK_1);
        if (lsb) begin i1 = i; q1 = q; v1 = 1'b1; end
        else begin i0 = i; q0 = q; v0 = 1'b1; end
        @(negedge CLK_1);
        v0 = 1'b0;
        v1 = 1'b0;
        o = obs(lsb);
        nvec++;
        if (o !== 5'b00000) begin
            nerr++;
            $display("FAIL %s accept: outputs=%b exp=00000", nm, o);
        end
        for (int j = 0; j < FL; j++) begin
            @(negedge CLK_1);
            o = obs(lsb);
            e = {1'b1, gold[FL-1-j], (j % 2 == 0), (j == 0), 1'b0};
            nvec++;
            if (o[3:0] !== e[3:0]) begin
                nerr++;
                $display("FAIL %s bit%0d: dac/ph/fs/un=%b exp=%b", nm, j, o[3:0], e[3:0]);
            end
        end
        @(negedge CLK_1);
        o = obs(lsb);
        nvec++;
        if (o !== 5'b10001) begin
            nerr++;
            $display("FAIL %s underrun: outputs=%b exp=10001", nm, o);
        end
        @(negedge CLK_1);
        o = obs(lsb);
        nvec++;
        if (o !== 5'b10000) begin
            nerr++;
            $display("FAIL %s post_idle: outputs=%b exp=10000", nm, o);
        end
    endtask

    // pairs in pi/pq are offered with IN_VALID held high throughout
    task automatic test_stream(input string nm);
        bit expq[$];
        int np;
        expq = {};
        np = pi.size();
        for (int n = 0; n < np; n++)
            for (int j = 0; j < FL; j++)
                expq.push_back(exp_bit(pi[n], pq[n], j, 1'b1));
        @(negedge CLK_1);
        fork
            begin
                int guard;
                for (int n = 0; n < np; n++) begin
                    i0 = pi[n];
                    q0 = pq[n];
                    v0 = 1'b1;
                    guard = 0;
                    while (!r0 && guard < 4 * FL) begin
                        @(negedge CLK_1);
                        guard++;
                    end
                    nvec++;
                    if (guard >= 4 * FL) begin
                        nerr++;
                        $display("FAIL %s ready_timeout pair%0d: ready=%b exp=1", nm, n, r0);
                    end
                    @(negedge CLK_1);
                    nvec++;
                    if (r0 !== 1'b0) begin
                        nerr++;
                        $display("FAIL %s ready_drop pair%0d: ready=%b exp=0", nm, n, r0);
                    end
                end
                v0 = 1'b0;
            end
            begin
                int guard;
                guard = 0;
                while (f0 !== 1'b1 && guard < 4 * FL) begin
                    @(negedge CLK_1);
                    guard++;
                end
                nvec++;
                if (guard >= 4 * FL) begin
                    nerr++;
                    $display("FAIL %s start_timeout: fs=%b exp=1", nm, f0);
                end
                for (int b = 0; b < expq.size(); b++) begin
                    if (b > 0) @(negedge CLK_1);
                    nvec++;
                    if ({d0, p0, f0, u0} !== {expq[b], (b % 2 == 0), (b % FL == 0), 1'b0}) begin
                        nerr++;
                        $display("FAIL %s bit%0d: dac/ph/fs/un=%b%b%b%b exp=%b%b%b0",
                                 nm, b, d0, p0, f0, u0, expq[b], (b % 2 == 0), (b % FL == 0));
                    end
                end
                @(negedge CLK_1);
                nvec++;
                if ({d0, p0, u0} !== 3'b001) begin
                    nerr++;
                    $display("FAIL %s final_underrun: dac/ph/un=%b%b%b exp=001", nm, d0, p0, u0);
                end
            end
        join
    endtask

    task automatic test_reset_midframe;
        logic [4:0] o;
        int guard;
        @(negedge CLK_1);
        i0 = 8'h5A;
        q0 = 8'hC3;
        v0 = 1'b1;
        @(negedge CLK_1);
        i0 = 8'h77;
        q0 = 8'h11;
        guard = 0;
        while (!r0 && guard < 10) begin
            @(negedge CLK_1);
            guard++;
        end
        @(negedge CLK_1);
        v0 = 1'b0;
        repeat (4) @(negedge CLK_1);
        nvec++;
        if (r0 !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid buffered: ready=%b exp=0", r0);
        end
        #2;
        RST = 1'b0;
        #1;
        o = obs(1'b0);
        nvec++;
        if (o !== 5'b10000) begin
            nerr++;
            $display("FAIL rst_mid async: outputs=%b exp=10000", o);
        end
        @(negedge CLK_1);
        RST = 1'b1;
        for (int c = 0; c < 3 * FL; c++) begin
            @(negedge CLK_1);
            o = obs(1'b0);
            nvec++;
            if (o !== 5'b10000) begin
                nerr++;
                $display("FAIL rst_mid quiet cyc%0d: outputs=%b exp=10000", c, o);
            end
        end
    endtask

    task automatic test_random_single(input bit lsb);
        logic [W-1:0] i;
        logic [W-1:0] q;
        logic [FL-1:0] g;
        i = W'($urandom);
        q = W'($urandom);
        for (int j = 0; j < FL; j++) g[FL-1-j] = exp_bit(i, q, j, !lsb);
        test_single(lsb ? "rand_lsb" : "rand_msb", lsb, i, q, g);
    endtask

    initial begin
        logic [W-1:0] base;
        test_reset;
        test_single("msb_a5_3c", 1'b0, 8'hA5, 8'h3C, 16'b1000110101110010);
        test_single("lsb_01_80", 1'b1, 8'h01, 8'h80, 16'b1000000000000001);
        pi = {8'hA5, 8'hFF};
        pq = {8'h3C, 8'h00};
        test_stream("b2b");
        base = W'($urandom);
        pi = {};
        pq = {};
        for (int n = 0; n < 6; n++) begin
            pi.push_back(base + W'(n));
            pq.push_back(W'($urandom));
        end
        test_stream("backpressure");
        test_reset_midframe;
        test_single("after_rst", 1'b0, 8'hA5, 8'h3C, 16'b1000110101110010);
        for (int n = 0; n < 3; n++) begin
            test_random_single(1'b0);
            test_random_single(1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
